// File: rtl/instr_fetch_decode_if.sv
// Program memory bus between the fetch/decode front end and instruction memory.
// master: drives Addr, receives Data; slave: the memory side.
interface instr_fetch_decode_if #(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
);
  logic [addr_bus-1:0]  Addr;
  logic [data_size-1:0] Data;

  modport master (
    output Addr,
    input  Data
  );

  modport slave (
    input  Addr,
    output Data
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC drives program memory, decodes opcode/operand
// into registered accumulator/RAM control strobes; stops on HLT until reset.
module instr_fetch_decode #(
  parameter int addr_bus  = 11,
  parameter int data_size = 16,
  parameter int opnd_bits = 11
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable,
  instr_fetch_decode_if.master bus,
  output logic [data_size-1:0] Operand,
  output logic [opnd_bits-1:0] DataAddr,
  output logic [1:0]           SelA,
  output logic                 SelB,
  output logic                 Op,
  output logic                 WrAcc,
  output logic                 WrRam,
  output logic                 RdRam,
  output logic                 IllegalOp,
  output logic                 Halted
);

  localparam logic [4:0] HLT  = 5'b00000;
  localparam logic [4:0] STO  = 5'b00001;
  localparam logic [4:0] LD   = 5'b00010;
  localparam logic [4:0] LDI  = 5'b00011;
  localparam logic [4:0] ADD  = 5'b00100;
  localparam logic [4:0] ADDI = 5'b00101;
  localparam logic [4:0] SUB  = 5'b00110;
  localparam logic [4:0] SUBI = 5'b00111;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       illegal;
  } ctl_t;

  state_t              state_q, state_d;
  ctl_t                ctl_q, ctl_d;
  logic [addr_bus-1:0] pc_q;
  logic [4:0]          opc;
  logic [opnd_bits-1:0] opnd;
  logic                fire;

  assign opc  = bus.Data[data_size-1 -: 5];
  assign opnd = bus.Data[opnd_bits-1:0];
  assign fire = (state_q == RUN) && Enable;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fire && opc == HLT) state_d = HALT;
  end

  // Stall, halt and HLT itself all yield an all-zero bubble.
  always_comb begin
    ctl_d = '0;
    if (fire) begin
      unique case (1'b1)
        opc == HLT: ;
        opc == STO: ctl_d.wr_ram = 1'b1;
        opc == LD: begin
          ctl_d.rd_ram = 1'b1;
          ctl_d.wr_acc = 1'b1;
        end
        opc == LDI: begin
          ctl_d.wr_acc = 1'b1;
          ctl_d.sel_a  = 2'd1;
        end
        opc == ADD: begin
          ctl_d.rd_ram = 1'b1;
          ctl_d.wr_acc = 1'b1;
          ctl_d.sel_a  = 2'd2;
        end
        opc == ADDI: begin
          ctl_d.wr_acc = 1'b1;
          ctl_d.sel_a  = 2'd2;
          ctl_d.sel_b  = 1'b1;
        end
        opc == SUB: begin
          ctl_d.rd_ram = 1'b1;
          ctl_d.wr_acc = 1'b1;
          ctl_d.sel_a  = 2'd2;
          ctl_d.op     = 1'b1;
        end
        opc == SUBI: begin
          ctl_d.wr_acc = 1'b1;
          ctl_d.sel_a  = 2'd2;
          ctl_d.sel_b  = 1'b1;
          ctl_d.op     = 1'b1;
        end
        default: ctl_d.illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctl_q    <= '0;
      pc_q     <= '0;
      Operand  <= '0;
      DataAddr <= '0;
    end else begin
      ctl_q <= ctl_d;
      if (fire) begin
        Operand  <= {{(data_size-opnd_bits){opnd[opnd_bits-1]}}, opnd};
        DataAddr <= opnd;
        // PC stays on the HLT word; wraps naturally otherwise.
        if (opc != HLT) pc_q <= pc_q + addr_bus'(1);
      end
    end
  end

  assign bus.Addr  = pc_q;
  assign WrAcc     = ctl_q.wr_acc;
  assign WrRam     = ctl_q.wr_ram;
  assign RdRam     = ctl_q.rd_ram;
  assign SelA      = ctl_q.sel_a;
  assign SelB      = ctl_q.sel_b;
  assign Op        = ctl_q.op;
  assign IllegalOp = ctl_q.illegal;
  assign Halted    = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode.
// Behavioural program memory answers Addr combinationally.
module tb_instr_fetch_decode;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [15:0] Operand;
  logic [10:0] DataAddr;
  logic [1:0]  SelA;
  logic        SelB, Op, WrAcc, WrRam, RdRam, IllegalOp, Halted;

  logic [15:0] mem [0:2047];
  int errors = 0;
  int checks = 0;

  instr_fetch_decode_if #(.addr_bus(11), .data_size(16)) imem ();

  assign imem.Data = mem[imem.Addr];

  instr_fetch_decode dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .bus(imem),
    .Operand(Operand), .DataAddr(DataAddr), .SelA(SelA), .SelB(SelB),
    .Op(Op), .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam),
    .IllegalOp(IllegalOp), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] enc(input logic [4:0] o, input logic [10:0] a);
    return {o, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic wa, input logic wr,
                         input logic rd, input logic [1:0] sa, input logic sb,
                         input logic o, input logic il);
    chk({tag, ".WrAcc"}, 32'(WrAcc), 32'(wa));
    chk({tag, ".WrRam"}, 32'(WrRam), 32'(wr));
    chk({tag, ".RdRam"}, 32'(RdRam), 32'(rd));
    chk({tag, ".SelA"}, 32'(SelA), 32'(sa));
    chk({tag, ".SelB"}, 32'(SelB), 32'(sb));
    chk({tag, ".Op"}, 32'(Op), 32'(o));
    chk({tag, ".Ill"}, 32'(IllegalOp), 32'(il));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic restart();
    Reset  = 1'b0;
    Enable = 1'b0;
    @(negedge Clk);
    Reset  = 1'b1;
    Enable = 1'b1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
  endtask

  task automatic load_prog();
    fill_nop();
    mem[0] = enc(5'd3, 11'd16);
    mem[1] = enc(5'd1, 11'd1);
    mem[2] = enc(5'd2, 11'd1);
    mem[3] = enc(5'd5, 11'd255);
    mem[4] = enc(5'd1, 11'd2);
    mem[5] = enc(5'd2, 11'd16);
    mem[6] = enc(5'd0, 11'd0);
  endtask

  initial begin
    Reset  = 1'b0;
    Enable = 1'b0;
    fill_nop();
    mem[0] = enc(5'd5, 11'd5);
    #2;
    chk("rst.Addr", 32'(imem.Addr), 32'd0);
    chk("rst.Operand", 32'(Operand), 32'd0);
    chk("rst.Halted", 32'(Halted), 32'd0);
    chk_ctl("rst", 0, 0, 0, 2'd0, 0, 0, 0);

    // reset asserted mid-run clears at once
    @(negedge Clk);
    Reset  = 1'b1;
    Enable = 1'b1;
    step();
    chk("t1.Addr", 32'(imem.Addr), 32'd1);
    chk("t1.Operand", 32'(Operand), 32'h0005);
    chk_ctl("t1.addi", 1, 0, 0, 2'd2, 1, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("t1r.Addr", 32'(imem.Addr), 32'd0);
    chk("t1r.Operand", 32'(Operand), 32'd0);
    chk("t1r.DataAddr", 32'(DataAddr), 32'd0);
    chk("t1r.Halted", 32'(Halted), 32'd0);
    chk_ctl("t1r", 0, 0, 0, 2'd0, 0, 0, 0);

    // program run to HLT
    load_prog();
    restart();
    step();
    chk_ctl("t2.ldi", 1, 0, 0, 2'd1, 0, 0, 0);
    chk("t2.ldi.Operand", 32'(Operand), 32'h0010);
    step();
    chk_ctl("t2.sto1", 0, 1, 0, 2'd0, 0, 0, 0);
    chk("t2.sto1.DataAddr", 32'(DataAddr), 32'd1);
    step();
    chk_ctl("t2.ld1", 1, 0, 1, 2'd0, 0, 0, 0);
    chk("t2.ld1.DataAddr", 32'(DataAddr), 32'd1);
    step();
    chk_ctl("t2.addi", 1, 0, 0, 2'd2, 1, 0, 0);
    chk("t2.addi.Operand", 32'(Operand), 32'h00FF);
    step();
    chk_ctl("t2.sto2", 0, 1, 0, 2'd0, 0, 0, 0);
    chk("t2.sto2.DataAddr", 32'(DataAddr), 32'd2);
    step();
    chk_ctl("t2.ld16", 1, 0, 1, 2'd0, 0, 0, 0);
    chk("t2.ld16.DataAddr", 32'(DataAddr), 32'd16);
    chk("t2.ld16.Addr", 32'(imem.Addr), 32'd6);
    chk("t2.ld16.Halted", 32'(Halted), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t2.hlt.Halted", 32'(Halted), 32'd1);
      chk("t2.hlt.Addr", 32'(imem.Addr), 32'd6);
      chk_ctl("t2.hlt", 0, 0, 0, 2'd0, 0, 0, 0);
    end
    chk("t2.hlt.DataAddr", 32'(DataAddr), 32'd0);

    // stall at Addr=3
    restart();
    step();
    step();
    step();
    chk("t3.Addr", 32'(imem.Addr), 32'd3);
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3.stall.Addr", 32'(imem.Addr), 32'd3);
      chk_ctl("t3.stall", 0, 0, 0, 2'd0, 0, 0, 0);
    end
    chk("t3.stall.DataAddr", 32'(DataAddr), 32'd1);
    Enable = 1'b1;
    step();
    chk("t3.res.Addr", 32'(imem.Addr), 32'd4);
    chk("t3.res.Operand", 32'(Operand), 32'h00FF);
    chk_ctl("t3.res", 1, 0, 0, 2'd2, 1, 0, 0);

    // negative operand sign extension
    fill_nop();
    mem[0] = enc(5'd7, 11'h7FF);
    restart();
    step();
    chk("t4.Operand", 32'(Operand), 32'hFFFF);
    chk("t4.DataAddr", 32'(DataAddr), 32'h7FF);
    chk_ctl("t4.subi", 1, 0, 0, 2'd2, 1, 1, 0);

    // illegal opcode at address 2
    mem[0] = enc(5'd3, 11'd1);
    mem[1] = enc(5'd6, 11'd4);
    mem[2] = enc(5'd31, 11'd0);
    mem[3] = enc(5'd1, 11'd3);
    restart();
    step();
    step();
    chk_ctl("t5.sub", 1, 0, 1, 2'd2, 0, 1, 0);
    step();
    chk_ctl("t5.ill", 0, 0, 0, 2'd0, 0, 0, 1);
    chk("t5.ill.Addr", 32'(imem.Addr), 32'd3);
    step();
    chk_ctl("t5.sto", 0, 1, 0, 2'd0, 0, 0, 0);
    chk("t5.sto.Addr", 32'(imem.Addr), 32'd4);

    // PC wrap through all-NOP memory
    fill_nop();
    restart();
    for (int i = 0; i < 2046; i++) step();
    chk("t6.Addr2046", 32'(imem.Addr), 32'd2046);
    step();
    chk("t6.Addr2047", 32'(imem.Addr), 32'd2047);
    step();
    chk("t6.Addr0", 32'(imem.Addr), 32'd0);
    chk("t6.Halted", 32'(Halted), 32'd0);
    chk_ctl("t6.nop", 0, 0, 0, 2'd0, 0, 0, 1);
    step();
    chk("t6.Addr1", 32'(imem.Addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
